// File: rtl/dtw_core_param_if.sv
// Control/data bundle between the AXI register wrapper (master) and the DTW core (slave).
interface dtw_core_param_if #(
    parameter int unsigned N_FEAT = 8,
    parameter int unsigned FEAT_W = 4,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned ADDR_W = 8
);
    logic                       wr_en;
    logic                       wr_sel;
    logic [ADDR_W-1:0]          wr_addr;
    logic [N_FEAT*FEAT_W-1:0]   wr_data;
    logic [ADDR_W:0]            tmp_len;
    logic [ADDR_W:0]            tst_len;
    logic [ADDR_W-1:0]          band;
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [ACC_W-1:0]           dtw_out;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, tmp_len, tst_len, band, start,
        input  busy, done, err, dtw_out
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, tmp_len, tst_len, band, start,
        output busy, done, err, dtw_out
    );
endinterface

// File: rtl/dtw_core_param.sv
// DTW engine: template/test frame RAMs, 2-stage read/distance pipeline and a two-row
// cost buffer; one cell per cycle with optional Sakoe-Chiba band and saturating costs.
module dtw_core_param #(
    parameter int unsigned N_FEAT  = 8,
    parameter int unsigned FEAT_W  = 4,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    dtw_core_param_if.slave bus
);

    localparam int unsigned FRAME_W = N_FEAT * FEAT_W;
    localparam int unsigned DIST_W  = FEAT_W + $clog2(N_FEAT);
    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned CNT_W   = 2 * LEN_W;
    localparam logic [ACC_W-1:0] INF = '1;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e state_q, state_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [ACC_W-1:0]   dtw_q, dtw_d;

    logic [LEN_W-1:0]   m_q;
    logic [CNT_W-1:0]   nm_q;
    logic [CNT_W-1:0]   cyc_q;
    logic [ADDR_W-1:0]  band_q;
    logic [ADDR_W-1:0]  ii_q, jj_q;
    logic               drain_q;

    logic               v1_q, v2_q;
    logic [ADDR_W-1:0]  i1_q, j1_q, i2_q, j2_q;
    logic [DIST_W-1:0]  dist_q;
    logic [ACC_W-1:0]   left_q;

    logic [FRAME_W-1:0] tmp_mem [MAX_LEN];
    logic [FRAME_W-1:0] tst_mem [MAX_LEN];
    logic [FRAME_W-1:0] tmp_rd_q, tst_rd_q;
    logic [ACC_W-1:0]   rowbuf  [2][MAX_LEN];

    logic               legal_c, launch_c, issue_c;
    logic [DIST_W-1:0]  dist_c;
    logic [ACC_W-1:0]   up_c, diag_c, left_c, min_c, cell_c;
    logic [ADDR_W-1:0]  gap_c;

    function automatic logic [FEAT_W-1:0] abs_diff(input logic [FEAT_W-1:0] a,
                                                   input logic [FEAT_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // INF is absorbing; any sum reaching the all-ones code clamps to INF
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (a == INF || b == INF || s >= {1'b0, INF}) return INF;
        return s[ACC_W-1:0];
    endfunction

    assign legal_c  = (bus.tmp_len != '0) && (bus.tmp_len <= LEN_W'(MAX_LEN)) &&
                      (bus.tst_len != '0) && (bus.tst_len <= LEN_W'(MAX_LEN));
    assign launch_c = (state_q == S_IDLE) && bus.start && legal_c;
    assign issue_c  = ((state_q == S_INIT) || (state_q == S_RUN)) && (cyc_q < nm_q);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dtw_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dtw_q   <= dtw_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch_c) state_d = S_INIT;
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (cyc_q == nm_q) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output next-values
    always_comb begin
        busy_d = (state_d == S_INIT) || (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
        err_d  = (state_q == S_IDLE) && bus.start && !legal_c;
        dtw_d  = dtw_q;
        if (state_q == S_DRAIN && state_d == S_DONE) dtw_d = left_q;
    end

    // Scan counters and pipeline control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q     <= '0;
            nm_q    <= '0;
            cyc_q   <= '0;
            band_q  <= '0;
            ii_q    <= '0;
            jj_q    <= '0;
            drain_q <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            i1_q    <= '0;
            j1_q    <= '0;
            i2_q    <= '0;
            j2_q    <= '0;
            dist_q  <= '0;
            left_q  <= '0;
        end else begin
            if (launch_c) begin
                m_q    <= bus.tmp_len;
                nm_q   <= CNT_W'(bus.tmp_len) * CNT_W'(bus.tst_len);
                band_q <= bus.band;
                cyc_q  <= '0;
                ii_q   <= '0;
                jj_q   <= '0;
            end else if (state_q == S_INIT || state_q == S_RUN) begin
                cyc_q <= cyc_q + CNT_W'(1);
                if (issue_c) begin
                    if ({1'b0, jj_q} == m_q - LEN_W'(1)) begin
                        jj_q <= '0;
                        ii_q <= ii_q + ADDR_W'(1);
                    end else begin
                        jj_q <= jj_q + ADDR_W'(1);
                    end
                end
            end
            drain_q <= (state_q == S_DRAIN) && !drain_q;
            v1_q    <= issue_c;
            i1_q    <= ii_q;
            j1_q    <= jj_q;
            v2_q    <= v1_q;
            i2_q    <= i1_q;
            j2_q    <= j1_q;
            dist_q  <= dist_c;
            if (v2_q) left_q <= cell_c;
        end
    end

    // Frame RAMs: read-first, host writes only while idle
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy_q) begin
            if (bus.wr_sel) tst_mem[bus.wr_addr] <= bus.wr_data;
            else            tmp_mem[bus.wr_addr] <= bus.wr_data;
        end
        if (issue_c) begin
            tmp_rd_q <= tmp_mem[jj_q];
            tst_rd_q <= tst_mem[ii_q];
        end
    end

    // Row i writes bank i[0]; the other bank holds row i-1
    always_ff @(posedge clk) begin
        if (v2_q) rowbuf[i2_q[0]][j2_q] <= cell_c;
    end

    always_comb begin
        dist_c = '0;
        for (int unsigned f = 0; f < N_FEAT; f++) begin
            dist_c = dist_c + DIST_W'(abs_diff(tst_rd_q[f*FEAT_W +: FEAT_W],
                                               tmp_rd_q[f*FEAT_W +: FEAT_W]));
        end
    end

    always_comb begin
        up_c   = INF;
        diag_c = INF;
        left_c = INF;
        if (i2_q != '0) begin
            up_c = rowbuf[!i2_q[0]][j2_q];
            if (j2_q != '0) diag_c = rowbuf[!i2_q[0]][j2_q - ADDR_W'(1)];
        end
        if (j2_q != '0) left_c = left_q;
        min_c = up_c;
        if (left_c < min_c) min_c = left_c;
        if (diag_c < min_c) min_c = diag_c;
        if (i2_q == '0 && j2_q == '0) cell_c = ACC_W'(dist_q);
        else                          cell_c = sat_add(min_c, ACC_W'(dist_q));
        gap_c = (i2_q > j2_q) ? (i2_q - j2_q) : (j2_q - i2_q);
        if (band_q != '0 && gap_c > band_q) cell_c = INF;
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.dtw_out = dtw_q;

endmodule

// File: tb/tb_dtw_core_param.sv
// Scoreboard bench for dtw_core_param: stimulus queues expected done/err events,
// a monitor per DUT pops and compares value and arrival cycle.
module tb_dtw_core_param;

    localparam int unsigned ADDR_W = 8;

    typedef struct {
        bit          is_err;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;

    exp_t  q32[$];
    exp_t  q8[$];
    string n32[$];
    string n8[$];
    exp_t  e32, e8;
    string s32, s8;
    logic [31:0] fr[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    dtw_core_param_if #(.N_FEAT(8), .FEAT_W(4), .ACC_W(32), .ADDR_W(8)) bif ();
    dtw_core_param_if #(.N_FEAT(8), .FEAT_W(4), .ACC_W(8),  .ADDR_W(8)) bif8 ();

    dtw_core_param #(.N_FEAT(8), .FEAT_W(4), .ACC_W(32), .MAX_LEN(256), .ADDR_W(8))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(bif));
    dtw_core_param #(.N_FEAT(8), .FEAT_W(4), .ACC_W(8), .MAX_LEN(256), .ADDR_W(8))
        u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bif8));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bif.done || bif.err)) begin
            if (q32.size() == 0) begin
                chk("dut32_unexpected_event", 32'({bif.done, bif.err}), 32'd0);
            end else begin
                e32 = q32.pop_front();
                s32 = n32.pop_front();
                chk({s32, "_kind"},  32'(bif.err), 32'(e32.is_err));
                chk({s32, "_dtw"},   bif.dtw_out, e32.val);
                chk({s32, "_cycle"}, 32'(cyc_cnt), 32'(e32.cyc));
                chk({s32, "_busy"},  32'(bif.busy), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (bif8.done || bif8.err)) begin
            if (q8.size() == 0) begin
                chk("dut8_unexpected_event", 32'({bif8.done, bif8.err}), 32'd0);
            end else begin
                e8 = q8.pop_front();
                s8 = n8.pop_front();
                chk({s8, "_kind"},  32'(bif8.err), 32'(e8.is_err));
                chk({s8, "_dtw"},   32'(bif8.dtw_out), e8.val);
                chk({s8, "_cycle"}, 32'(cyc_cnt), 32'(e8.cyc));
            end
        end
    end

    task automatic write32(input bit sel, input int addr, input logic [31:0] data);
        bif.wr_en   = 1'b1;
        bif.wr_sel  = sel;
        bif.wr_addr = ADDR_W'(addr);
        bif.wr_data = data;
        @(negedge clk);
        bif.wr_en   = 1'b0;
    endtask

    task automatic write8(input bit sel, input int addr, input logic [31:0] data);
        bif8.wr_en   = 1'b1;
        bif8.wr_sel  = sel;
        bif8.wr_addr = ADDR_W'(addr);
        bif8.wr_data = data;
        @(negedge clk);
        bif8.wr_en   = 1'b0;
    endtask

    task automatic start32(input int m, input int n, input int band);
        bif.tmp_len = (ADDR_W+1)'(m);
        bif.tst_len = (ADDR_W+1)'(n);
        bif.band    = ADDR_W'(band);
        bif.start   = 1'b1;
        @(negedge clk);
        bif.start   = 1'b0;
    endtask

    task automatic push32(input string name, input bit is_err, input logic [31:0] val,
                          input int lat);
        exp_t e;
        e.is_err = is_err;
        e.val    = val;
        e.cyc    = cyc_cnt + 1 + lat;
        q32.push_back(e);
        n32.push_back(name);
    endtask

    task automatic drain32(input string name);
        for (int k = 0; k < 3000 && q32.size() != 0; k++) @(negedge clk);
        if (q32.size() != 0) begin
            chk({name, "_timeout"}, 32'(q32.size()), 32'd0);
            q32.delete();
            n32.delete();
        end
        @(negedge clk);
    endtask

    // Done expected N*M+3 edges after the sampling edge; err on the sampling edge
    task automatic run32(input string name, input int m, input int n, input int band,
                         input logic [31:0] val, input bit is_err);
        push32(name, is_err, val, is_err ? 0 : m * n + 3);
        start32(m, n, band);
        chk({name, "_busy_after_start"}, 32'(bif.busy), is_err ? 32'd0 : 32'd1);
        drain32(name);
    endtask

    task automatic run8(input string name, input int m, input int n, input logic [31:0] val);
        exp_t e;
        e.is_err = 1'b0;
        e.val    = val;
        e.cyc    = cyc_cnt + 1 + m * n + 3;
        q8.push_back(e);
        n8.push_back(name);
        bif8.tmp_len = (ADDR_W+1)'(m);
        bif8.tst_len = (ADDR_W+1)'(n);
        bif8.band    = '0;
        bif8.start   = 1'b1;
        @(negedge clk);
        bif8.start   = 1'b0;
        for (int k = 0; k < 3000 && q8.size() != 0; k++) @(negedge clk);
        if (q8.size() != 0) begin
            chk({name, "_timeout"}, 32'(q8.size()), 32'd0);
            q8.delete();
            n8.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        bif.wr_en = 0; bif.wr_sel = 0; bif.wr_addr = '0; bif.wr_data = '0;
        bif.tmp_len = '0; bif.tst_len = '0; bif.band = '0; bif.start = 0;
        bif8.wr_en = 0; bif8.wr_sel = 0; bif8.wr_addr = '0; bif8.wr_data = '0;
        bif8.tmp_len = '0; bif8.tst_len = '0; bif8.band = '0; bif8.start = 0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bif.busy), 32'd0);
        chk("reset_done", 32'(bif.done), 32'd0);
        chk("reset_err",  32'(bif.err),  32'd0);
        chk("reset_dtw",  bif.dtw_out,   32'd0);
        chk("reset_dtw8", 32'(bif8.dtw_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identical random sequences: zero distance, done 20 cycles after start
        for (int k = 0; k < 4; k++) fr[k] = $urandom;
        for (int k = 0; k < 4; k++) begin
            write32(1'b0, k, fr[k]);
            write32(1'b1, k, fr[k]);
        end
        run32("t1_identical", 4, 4, 0, 32'd0, 1'b0);

        // Template zeros, test all-ones features: 8 per cell
        for (int k = 0; k < 5; k++) begin
            write32(1'b0, k, 32'h0000_0000);
            write32(1'b1, k, 32'h1111_1111);
        end
        run32("t2_diag", 3, 3, 0, 32'd24, 1'b0);

        // Illegal lengths keep the previous result
        run32("t5_tmp0",   0,   3, 0, 32'd24, 1'b1);
        run32("t5_tst0",   3,   0, 0, 32'd24, 1'b1);
        run32("t5_tmp257", 257, 3, 0, 32'd24, 1'b1);

        // Band blocks the end cell at 1, admits |i-j|==band at 3
        run32("t3_band1", 2, 5, 1, 32'hFFFF_FFFF, 1'b0);
        run32("t3_band3", 2, 5, 3, 32'd40, 1'b0);
        run32("t3_band0", 2, 5, 0, 32'd40, 1'b0);

        // Single cell, differences in both directions: 4*14 + 4*1
        write32(1'b0, 0, 32'h0F0F_0F0F);
        run32("t2_single", 1, 1, 0, 32'd60, 1'b0);

        // Reset mid-run: no done, outputs cleared
        start32(3, 3, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(bif.busy), 32'd0);
        chk("t6_rst_done", 32'(bif.done), 32'd0);
        chk("t6_rst_dtw",  bif.dtw_out,   32'd0);
        q32.delete();
        n32.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_post_rst_busy", 32'(bif.busy), 32'd0);
        chk("t6_post_rst_dtw",  bif.dtw_out,   32'd0);

        // Narrow accumulator saturates
        for (int k = 0; k < 3; k++) begin
            write8(1'b0, k, 32'h0000_0000);
            write8(1'b1, k, 32'hFFFF_FFFF);
        end
        run8("t4_sat", 3, 3, 32'h0000_00FF);
        run8("t4_nosat", 2, 2, 32'h0000_00F0);

        // Second start and writes during busy are ignored
        for (int k = 0; k < 4; k++) fr[k] = $urandom;
        for (int k = 0; k < 4; k++) begin
            write32(1'b0, k, fr[k]);
            write32(1'b1, k, fr[k]);
        end
        push32("t6_busy_ignored", 1'b0, 32'd0, 19);
        start32(4, 4, 0);
        chk("t6_busy_after_start", 32'(bif.busy), 32'd1);
        repeat (2) @(negedge clk);
        start32(0, 4, 0);
        write32(1'b0, 0, ~fr[0]);
        write32(1'b1, 2, ~fr[2]);
        drain32("t6_busy_ignored");
        run32("t6_rerun", 4, 4, 0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
